// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
// Control bus between the CPU sequencer and the 16-bit datapath.
//   opcode, za     : datapath -> sequencer (IR opcode field, ALU zero flag for A)
//   loadIR, incPC,
//   loadPC, loadA,
//   loadB, loadC   : register load strobes
//   mode           : ALU mode (0 = arithmetic, 1 = logic)
//   we_DM          : data-memory write enable
//   selA, selB     : muxA (0 ALU / 1 immediate), muxB (0 PC / 1 external address)
// Modports: master = sequencer side, slave = datapath side.
// ---------------------------------------------------------------------------
interface cpu_sequencer_if;
    logic [3:0] opcode;
    logic       za;
    logic       loadIR;
    logic       incPC;
    logic       loadPC;
    logic       loadA;
    logic       loadB;
    logic       loadC;
    logic       mode;
    logic       we_DM;
    logic       selA;
    logic       selB;

    modport master (
        input  opcode, za,
        output loadIR, incPC, loadPC, loadA, loadB, loadC,
               mode, we_DM, selA, selB
    );

    modport slave (
        output opcode, za,
        input  loadIR, incPC, loadPC, loadA, loadB, loadC,
               mode, we_DM, selA, selB
    );
endinterface

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control FSM for the 16-bit CPU datapath, with run/idle/halt
// control and MEM_WAIT extra data-memory wait cycles before operands load.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : run enable, sampled in IDLE and in final instruction cycles
//   bus        : control bus (master modport), see cpu_sequencer_if
//   busy       : high in every state except IDLE and HALT
//   instr_done : one-cycle pulse in the final cycle of each instruction
//   state      : current state encoding (debug)
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int MEM_WAIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    cpu_sequencer_if.master    bus,
    output logic               busy,
    output logic               instr_done,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_OPRD   = 3'd3,
        S_EXEC   = 3'd4,
        S_STORE  = 3'd5,
        S_JUMP   = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);
    localparam logic [3:0] OP_LDI    = 4'b1100;

    state_e     state_q, state_d;
    logic [3:0] op_q,    op_d;
    logic [2:0] wait_q,  wait_d;
    logic       mode_q,  mode_d;

    logic load_ir, inc_pc, load_pc, load_ab, load_c;
    logic mode_o, we_dm, sel_a, sel_b, done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            wait_q  <= 3'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = wait_q;
        mode_d  = mode_q;
        load_ir = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        load_ab = 1'b0;
        load_c  = 1'b0;
        mode_o  = 1'b0;
        we_dm   = 1'b0;
        sel_a   = 1'b0;
        sel_b   = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // External loader owns the instruction-memory address while idle.
                sel_b = 1'b1;
                if (en) state_d = S_FETCH;
            end

            S_FETCH: begin
                load_ir = 1'b1;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                // opcode comes straight from the IR flops, loaded at the end of
                // FETCH, so it is stable for the whole DECODE cycle.
                inc_pc = 1'b1;
                op_d   = bus.opcode;
                if (!bus.opcode[3]) begin
                    mode_d  = 1'b0;
                    wait_d  = WAIT_INIT;
                    state_d = S_OPRD;
                end else if (bus.opcode[3:2] == 2'b10) begin
                    mode_o  = 1'b1;
                    mode_d  = 1'b1;
                    wait_d  = WAIT_INIT;
                    state_d = S_OPRD;
                end else begin
                    mode_d = 1'b0;
                    unique case (bus.opcode[1:0])
                        2'b00: state_d = S_EXEC;        // LDI
                        2'b01: state_d = S_JUMP;        // JMP
                        2'b10: begin                    // JZ
                            if (bus.za) begin
                                state_d = S_JUMP;
                            end else begin
                                // Untaken JZ finishes here.
                                done    = 1'b1;
                                state_d = en ? S_FETCH : S_IDLE;
                            end
                        end
                        default: state_d = S_HALT;      // HALT
                    endcase
                end
            end

            S_OPRD: begin
                // Memory read is held until the wait counter drains; operands
                // are captured only in the last held cycle.
                mode_o = mode_q;
                if (wait_q == 3'd0) begin
                    load_ab = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end

            S_EXEC: begin
                load_c  = 1'b1;
                sel_a   = (op_q == OP_LDI);
                mode_o  = mode_q;
                state_d = S_STORE;
            end

            S_STORE: begin
                we_dm   = 1'b1;
                done    = 1'b1;
                state_d = en ? S_FETCH : S_IDLE;
            end

            S_JUMP: begin
                load_pc = 1'b1;
                done    = 1'b1;
                state_d = en ? S_FETCH : S_IDLE;
            end

            S_HALT: begin
                // Sticky until reset; en is ignored.
                state_d = S_HALT;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.loadIR = load_ir;
    assign bus.incPC  = inc_pc;
    assign bus.loadPC = load_pc;
    assign bus.loadA  = load_ab;
    assign bus.loadB  = load_ab;
    assign bus.loadC  = load_c;
    assign bus.mode   = mode_o;
    assign bus.we_DM  = we_dm;
    assign bus.selA   = sel_a;
    assign bus.selB   = sel_b;

    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign instr_done = done;
    assign state      = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed bench for cpu_sequencer. Two instances: u0 with MEM_WAIT=1 and
// u1 with MEM_WAIT=3. Expected per-cycle control vectors are queued as each
// step is driven, then popped and compared as the cycles elapse.
// Vector layout: {state[2:0], loadIR, incPC, loadPC, loadA, loadB, loadC,
//                 mode, we_DM, selA, selB, instr_done, busy}
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, OPRD = 3'd3,
                           EXEC = 3'd4, STORE = 3'd5, JUMP = 3'd6, HALT = 3'd7;

    localparam logic [10:0] C_NONE = 11'h000, C_IR = 11'h400, C_INC = 11'h200,
                            C_PC = 11'h100, C_AB = 11'h0C0, C_C = 11'h020,
                            C_MD = 11'h010, C_WE = 11'h008, C_SA = 11'h004,
                            C_SB = 11'h002, C_DN = 11'h001;

    logic clk = 1'b0;
    logic rst_n0, rst_n1, en;
    logic [3:0] opcode;
    logic za;
    logic busy0, done0, busy1, done1;
    logic [2:0] st0, st1;
    logic sel;

    int n_pass  = 0;
    int n_total = 0;
    int step    = 0;

    logic [14:0] exp_q[$];
    logic [14:0] obs0, obs1;

    cpu_sequencer_if if0 ();
    cpu_sequencer_if if1 ();

    assign if0.opcode = opcode;
    assign if0.za     = za;
    assign if1.opcode = opcode;
    assign if1.za     = za;

    cpu_sequencer #(.MEM_WAIT(1)) u0 (
        .clk(clk), .rst_n(rst_n0), .en(en), .bus(if0.master),
        .busy(busy0), .instr_done(done0), .state(st0)
    );

    cpu_sequencer #(.MEM_WAIT(3)) u1 (
        .clk(clk), .rst_n(rst_n1), .en(en), .bus(if1.master),
        .busy(busy1), .instr_done(done1), .state(st1)
    );

    always #5 clk = ~clk;

    assign obs0 = {st0, if0.loadIR, if0.incPC, if0.loadPC, if0.loadA, if0.loadB,
                   if0.loadC, if0.mode, if0.we_DM, if0.selA, if0.selB, done0, busy0};
    assign obs1 = {st1, if1.loadIR, if1.incPC, if1.loadPC, if1.loadA, if1.loadB,
                   if1.loadC, if1.mode, if1.we_DM, if1.selA, if1.selB, done1, busy1};

    task automatic push(input logic [2:0] st, input logic [10:0] ctl);
        logic b;
        b = (st != IDLE) && (st != HALT);
        exp_q.push_back({st, ctl, b});
    endtask

    task automatic chk();
        logic [14:0] e, o;
        n_total++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 15'h7fff;
        o = sel ? obs1 : obs0;
        assert (o === e) n_pass++;
        else $error("FAIL ctl step=%0d dut=u%0d got=%h exp=%h", step, sel, o, e);
    endtask

    // One check per cycle, sampled on the falling edge; returns at posedge+1.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        sel = 1'b0; en = 1'b0; opcode = 4'd0; za = 1'b0;
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        #2;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        #1;
        // 1: reset state, then idle with en low
        step = 1;
        push(IDLE, C_SB); chk();
        @(posedge clk); #1;
        push(IDLE, C_SB); push(IDLE, C_SB); run(2);
        rst_n0 = 1'b1;
        for (int i = 0; i < 10; i++) push(IDLE, C_SB);
        run(10);

        // 2: ADD, MEM_WAIT=1
        step = 2; en = 1'b1; opcode = 4'b0001;
        push(IDLE, C_SB); push(FETCH, C_IR); push(DECODE, C_INC);
        push(OPRD, C_NONE); push(OPRD, C_AB); push(EXEC, C_C);
        push(STORE, C_WE | C_DN);
        run(7);

        // 3: LDI
        step = 3; opcode = 4'b1100;
        push(FETCH, C_IR); push(DECODE, C_INC); push(EXEC, C_C | C_SA);
        push(STORE, C_WE | C_DN);
        run(4);

        // 4: logic op 1010, mode=1 through EXEC
        step = 4; opcode = 4'b1010;
        push(FETCH, C_IR); push(DECODE, C_INC | C_MD); push(OPRD, C_MD);
        push(OPRD, C_AB | C_MD); push(EXEC, C_C | C_MD); push(STORE, C_WE | C_DN);
        run(6);

        // 5: JZ taken
        step = 5; opcode = 4'b1110; za = 1'b1;
        push(FETCH, C_IR); push(DECODE, C_INC); push(JUMP, C_PC | C_DN);
        run(3);

        // 6: JZ not taken
        step = 6; za = 1'b0;
        push(FETCH, C_IR); push(DECODE, C_INC | C_DN);
        run(2);

        // 7: JMP
        step = 7; opcode = 4'b1101;
        push(FETCH, C_IR); push(DECODE, C_INC); push(JUMP, C_PC | C_DN);
        run(3);

        // 8: en dropped in OPRD; instruction still completes, then idle
        step = 8; opcode = 4'b0011;
        push(FETCH, C_IR); push(DECODE, C_INC); push(OPRD, C_NONE);
        run(3);
        en = 1'b0;
        push(OPRD, C_AB); push(EXEC, C_C); push(STORE, C_WE | C_DN);
        push(IDLE, C_SB); push(IDLE, C_SB);
        run(5);

        // 9: reset during EXEC -> immediate IDLE, no store
        step = 9; en = 1'b1; opcode = 4'b0000;
        push(IDLE, C_SB); push(FETCH, C_IR); push(DECODE, C_INC);
        push(OPRD, C_NONE); push(OPRD, C_AB);
        run(5);
        #1; push(EXEC, C_C); chk();
        rst_n0 = 1'b0;
        #1; push(IDLE, C_SB); chk();
        @(posedge clk); #1;
        push(IDLE, C_SB); run(1);
        rst_n0 = 1'b1; en = 1'b0;
        push(IDLE, C_SB); run(1);

        // 10: HALT is sticky regardless of en, exits on reset
        step = 10; en = 1'b1; opcode = 4'b1111;
        push(IDLE, C_SB); push(FETCH, C_IR); push(DECODE, C_INC); push(HALT, C_NONE);
        run(4);
        for (int i = 0; i < 20; i++) begin
            en = ~en;
            push(HALT, C_NONE);
            run(1);
        end
        rst_n0 = 1'b0;
        #1; push(IDLE, C_SB); chk();
        @(posedge clk); #1;
        rst_n0 = 1'b1; en = 1'b0;
        push(IDLE, C_SB); run(1);

        // 11: MEM_WAIT=3 instance, OPRD held 4 cycles
        step = 11; sel = 1'b1; rst_n1 = 1'b1; en = 1'b1; opcode = 4'b0010;
        push(IDLE, C_SB); push(FETCH, C_IR); push(DECODE, C_INC);
        push(OPRD, C_NONE); push(OPRD, C_NONE); push(OPRD, C_NONE);
        push(OPRD, C_AB); push(EXEC, C_C); push(STORE, C_WE | C_DN);
        push(FETCH, C_IR);
        run(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
